// File: rtl/alu_issue_queue_pkg.sv
// Shared definitions for the ALU issue queue.
//   - ALU function-code constants (passed through unchecked by the queue).
//   - iq_entry_t: one queued op. Tags are stored at TagWMax bits and zero-extended
//     from the instance TAG_W, so the record type does not depend on a parameter.
package alu_issue_queue_pkg;

  // Widest physical tag an instance may use (TAG_W <= TagWMax).
  localparam int unsigned TagWMax = 16;

  localparam logic [5:0] arithAdd  = 6'd1;
  localparam logic [5:0] arithSub  = 6'd2;
  localparam logic [5:0] arithShra = 6'd3;
  localparam logic [5:0] logicAnd  = 6'd4;
  localparam logic [5:0] logicOr   = 6'd5;
  localparam logic [5:0] logicShl  = 6'd6;
  localparam logic [5:0] logicShrl = 6'd7;
  localparam logic [5:0] logicXor  = 6'd8;

  typedef struct packed {
    logic [5:0]                    func;
    logic [4:0]                    c0;
    logic [TagWMax-1:0]            destTag;
    logic [1:0]                    srcReady;
    logic [1:0][TagWMax-1:0]       srcTag;
    logic [1:0][31:0]              srcData;
  } iq_entry_t;

endpackage

// File: rtl/alu_iq_entry_wakeup.sv
// Per-entry wakeup: compares each not-yet-ready source tag against the result
// broadcast and, on a hit, captures the broadcast value and marks the source ready.
// Ports:
//   entry_cur  current contents of the entry
//   res_valid  result broadcast valid
//   res_tag    broadcast tag, zero-extended to TagWMax
//   res_data   broadcast value
//   entry_nxt  entry with any wakeup applied
module alu_iq_entry_wakeup
  import alu_issue_queue_pkg::*;
(
  input  iq_entry_t          entry_cur,
  input  logic               res_valid,
  input  logic [TagWMax-1:0] res_tag,
  input  logic [31:0]        res_data,
  output iq_entry_t          entry_nxt
);

  always_comb begin
    entry_nxt = entry_cur;
    for (int s = 0; s < 2; s++) begin
      if (res_valid && !entry_cur.srcReady[s] && (entry_cur.srcTag[s] == res_tag)) begin
        entry_nxt.srcReady[s] = 1'b1;
        entry_nxt.srcData[s]  = res_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Age-ordered (compacting) ALU issue queue with tag wakeup and a registered issue
// stage. Entry 0 is the oldest; inserts append at position count, and an issued
// entry is removed with all younger entries shifting down one.
//
// Ports:
//   clk, reset (sync, active-high), en (global enable; reset overrides it)
//   inValid/inReady, inFunc, inC0, inDestTag, inSrcReady, inSrcTag, inSrcData : insert
//     (source 0 occupies the low slice of inSrcTag/inSrcData)
//   resValid, resTag, resData : result broadcast for wakeup
//   allow : ALU accepts the issue register at this edge
//   flush : drop all queued ops and the pending issue
//   issueValid, funcSelect, dataIn0, dataIn1, c0, issueTag : registered ALU op
//
// Build option: define ALU_IQ_BYPASS_EN to let select see a same-edge broadcast
// as ready and forward resData straight into the issue register.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               inValid,
  output logic               inReady,
  input  logic [5:0]         inFunc,
  input  logic [4:0]         inC0,
  input  logic [TAG_W-1:0]   inDestTag,
  input  logic [1:0]         inSrcReady,
  input  logic [2*TAG_W-1:0] inSrcTag,
  input  logic [63:0]        inSrcData,
  input  logic               resValid,
  input  logic [TAG_W-1:0]   resTag,
  input  logic [31:0]        resData,
  input  logic               allow,
  input  logic               flush,
  output logic               issueValid,
  output logic [5:0]         funcSelect,
  output logic [31:0]        dataIn0,
  output logic [31:0]        dataIn1,
  output logic [4:0]         c0,
  output logic [TAG_W-1:0]   issueTag
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

`ifdef ALU_IQ_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  iq_entry_t          entries_q [DEPTH];
  iq_entry_t          entries_d [DEPTH];
  iq_entry_t          woken     [DEPTH];
  iq_entry_t          new_entry;
  logic [CntW-1:0]    count_q, count_d;
  logic [TagWMax-1:0] res_tag_ext;

  logic               issue_valid_q, issue_valid_d;
  logic [5:0]         func_q, func_d;
  logic [31:0]        data0_q, data0_d;
  logic [31:0]        data1_q, data1_d;
  logic [4:0]         c0_q, c0_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [DEPTH-1:0]   eligible;
  logic               sel_found;
  int                 sel_idx;
  int                 ins_pos;
  logic               do_ins, do_iss;

  assign res_tag_ext = TagWMax'(resTag);
  assign inReady     = (count_q < CntW'(DEPTH));
  assign do_ins      = inValid && inReady;
  assign do_iss      = allow && sel_found;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wakeup
    alu_iq_entry_wakeup u_wakeup (
      .entry_cur (entries_q[g]),
      .res_valid (resValid),
      .res_tag   (res_tag_ext),
      .res_data  (resData),
      .entry_nxt (woken[g])
    );
  end

  // The incoming op sees the same broadcast so a wakeup on its insert edge is not lost.
  always_comb begin
    new_entry          = '0;
    new_entry.func     = inFunc;
    new_entry.c0       = inC0;
    new_entry.destTag  = TagWMax'(inDestTag);
    for (int s = 0; s < 2; s++) begin
      new_entry.srcReady[s] = inSrcReady[s];
      new_entry.srcTag[s]   = TagWMax'(inSrcTag[s*TAG_W +: TAG_W]);
      new_entry.srcData[s]  = inSrcData[s*32 +: 32];
      if (resValid && !inSrcReady[s] && (new_entry.srcTag[s] == res_tag_ext)) begin
        new_entry.srcReady[s] = 1'b1;
        new_entry.srcData[s]  = resData;
      end
    end
  end

  // Oldest eligible entry. With bypass, readiness includes this edge's broadcast;
  // without it, only flags already captured in the entry count.
  always_comb begin
    eligible  = '0;
    sel_found = 1'b0;
    sel_idx   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = (i < int'(count_q)) &&
                    (Bypass ? (&woken[i].srcReady) : (&entries_q[i].srcReady));
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = woken[i];
    end
    count_d       = count_q;
    issue_valid_d = issue_valid_q;
    func_d        = func_q;
    data0_d       = data0_q;
    data1_d       = data1_q;
    c0_d          = c0_q;
    tag_d         = tag_q;
    ins_pos       = int'(count_q);

    if (allow) begin
      issue_valid_d = sel_found;
      for (int i = 0; i < DEPTH; i++) begin
        if (sel_found && (i == sel_idx)) begin
          func_d  = woken[i].func;
          c0_d    = woken[i].c0;
          tag_d   = woken[i].destTag[TAG_W-1:0];
          data0_d = woken[i].srcData[0];
          data1_d = woken[i].srcData[1];
        end
      end
    end

    if (do_iss) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= sel_idx) begin
          entries_d[i] = woken[i+1];
        end
      end
      ins_pos = int'(count_q) - 1;
    end

    if (do_ins) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == ins_pos) begin
          entries_d[i] = new_entry;
        end
      end
    end

    count_d = count_q + CntW'(do_ins) - CntW'(do_iss);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      func_q        <= '0;
      data0_q       <= '0;
      data1_q       <= '0;
      c0_q          <= '0;
      tag_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else if (en) begin
      if (flush) begin
        count_q       <= '0;
        issue_valid_q <= 1'b0;
      end else begin
        count_q       <= count_d;
        issue_valid_q <= issue_valid_d;
        func_q        <= func_d;
        data0_q       <= data0_d;
        data1_q       <= data1_d;
        c0_q          <= c0_d;
        tag_q         <= tag_d;
        for (int i = 0; i < DEPTH; i++) begin
          entries_q[i] <= entries_d[i];
        end
      end
    end
  end

  assign issueValid = issue_valid_q;
  assign funcSelect = func_q;
  assign dataIn0    = data0_q;
  assign dataIn1    = data1_q;
  assign c0         = c0_q;
  assign issueTag   = tag_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 6;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b1;
  logic               inValid = 1'b0;
  logic               inReady;
  logic [5:0]         inFunc = '0;
  logic [4:0]         inC0 = '0;
  logic [TAG_W-1:0]   inDestTag = '0;
  logic [1:0]         inSrcReady = '0;
  logic [2*TAG_W-1:0] inSrcTag = '0;
  logic [63:0]        inSrcData = '0;
  logic               resValid = 1'b0;
  logic [TAG_W-1:0]   resTag = '0;
  logic [31:0]        resData = '0;
  logic               allow = 1'b0;
  logic               flush = 1'b0;
  logic               issueValid;
  logic [5:0]         funcSelect;
  logic [31:0]        dataIn0, dataIn1;
  logic [4:0]         c0;
  logic [TAG_W-1:0]   issueTag;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .inValid    (inValid),
    .inReady    (inReady),
    .inFunc     (inFunc),
    .inC0       (inC0),
    .inDestTag  (inDestTag),
    .inSrcReady (inSrcReady),
    .inSrcTag   (inSrcTag),
    .inSrcData  (inSrcData),
    .resValid   (resValid),
    .resTag     (resTag),
    .resData    (resData),
    .allow      (allow),
    .flush      (flush),
    .issueValid (issueValid),
    .funcSelect (funcSelect),
    .dataIn0    (dataIn0),
    .dataIn1    (dataIn1),
    .c0         (c0),
    .issueTag   (issueTag)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [5:0]       func;
    logic [4:0]       sh;
    logic [TAG_W-1:0] tag;
    logic [31:0]      d0;
    logic [31:0]      d1;
  } exp_t;

  exp_t sb[$];

  // Scoreboard: every newly loaded issue register must match the next expected op.
  logic mon_load;
  always @(posedge clk) begin
    mon_load = en && !reset && !flush && allow;
    #1;
    if (mon_load && issueValid) begin
      exp_t got;
      exp_t want;
      got.func = funcSelect;
      got.sh   = c0;
      got.tag  = issueTag;
      got.d0   = dataIn0;
      got.d1   = dataIn1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_issue got func=%0d tag=%0d d0=%h d1=%h want none",
                 got.func, got.tag, got.d0, got.d1);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL sb_issue got func=%0d c0=%0d tag=%0d d0=%h d1=%h want func=%0d c0=%0d tag=%0d d0=%h d1=%h",
                   got.func, got.sh, got.tag, got.d0, got.d1,
                   want.func, want.sh, want.tag, want.d0, want.d1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [5:0] f, input logic [4:0] sh, input logic [5:0] dt,
                          input logic [1:0] rdy, input logic [5:0] t0, input logic [5:0] t1,
                          input logic [31:0] d0, input logic [31:0] d1);
    inValid    = 1'b1;
    inFunc     = f;
    inC0       = sh;
    inDestTag  = dt;
    inSrcReady = rdy;
    inSrcTag   = {t1, t0};
    inSrcData  = {d1, d0};
  endtask

  task automatic push_exp(input logic [5:0] f, input logic [4:0] sh, input logic [5:0] dt,
                          input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    e.func = f;
    e.sh   = sh;
    e.tag  = dt;
    e.d0   = d0;
    e.d1   = d1;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL reset_issue_valid got=%b want=0", issueValid);
    end
    checks++;
    if ({funcSelect, dataIn0, dataIn1, c0, issueTag} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got func=%0d d0=%h d1=%h c0=%0d tag=%0d want all 0",
               funcSelect, dataIn0, dataIn1, c0, issueTag);
    end
    tick();
    checks++;
    if (inReady !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", inReady);
    end
  endtask

  task automatic test_basic();
    allow = 1'b1;
    drive_op(arithAdd, 5'd3, 6'd9, 2'b11, 6'd0, 6'd0, 32'd5, 32'd7);
    push_exp(arithAdd, 5'd3, 6'd9, 32'd5, 32'd7);
    tick();
    inValid = 1'b0;
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL basic_not_early got=%b want=0", issueValid);
    end
    tick();
    checks++;
    if ({issueValid, funcSelect, dataIn0, dataIn1} !== {1'b1, 6'd1, 32'd5, 32'd7}) begin
      failures++;
      $display("FAIL basic_issue got v=%b func=%0d d0=%0d d1=%0d want v=1 func=1 d0=5 d1=7",
               issueValid, funcSelect, dataIn0, dataIn1);
    end
    tick();
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL basic_drain got=%b want=0", issueValid);
    end
  endtask

  task automatic test_wakeup();
    allow = 1'b1;
    drive_op(arithSub, 5'd0, 6'd10, 2'b01, 6'd1, 6'd3, 32'h20, 32'h0);
    push_exp(arithSub, 5'd0, 6'd10, 32'h20, 32'h10);
    tick();
    inValid = 1'b0;
    tick();
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL wakeup_waiting got=%b want=0", issueValid);
    end
    resValid = 1'b1;
    resTag   = 6'd3;
    resData  = 32'h10;
    tick();
    resValid = 1'b0;
`ifdef ALU_IQ_BYPASS_EN
    checks++;
    if ({issueValid, dataIn1} !== {1'b1, 32'h10}) begin
      failures++;
      $display("FAIL wakeup_bypass got v=%b d1=%h want v=1 d1=10", issueValid, dataIn1);
    end
`else
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL wakeup_capture_edge got=%b want=0", issueValid);
    end
    tick();
    checks++;
    if ({issueValid, dataIn1} !== {1'b1, 32'h10}) begin
      failures++;
      $display("FAIL wakeup_issue got v=%b d1=%h want v=1 d1=10", issueValid, dataIn1);
    end
`endif
    tick();
  endtask

  task automatic test_same_edge_wakeup();
    allow = 1'b1;
    drive_op(logicOr, 5'd0, 6'd11, 2'b10, 6'd5, 6'd0, 32'h0, 32'hF0);
    resValid = 1'b1;
    resTag   = 6'd5;
    resData  = 32'h55;
    push_exp(logicOr, 5'd0, 6'd11, 32'h55, 32'hF0);
    tick();
    inValid  = 1'b0;
    resValid = 1'b0;
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL same_edge_not_early got=%b want=0", issueValid);
    end
    tick();
    checks++;
    if ({issueValid, dataIn0} !== {1'b1, 32'h55}) begin
      failures++;
      $display("FAIL same_edge_capture got v=%b d0=%h want v=1 d0=55", issueValid, dataIn0);
    end
    tick();
  endtask

  task automatic test_full();
    allow = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_op(6'(4 + k), 5'd0, 6'(20 + k), 2'b11, 6'd0, 6'd0, 32'(100 + k), 32'(200 + k));
      push_exp(6'(4 + k), 5'd0, 6'(20 + k), 32'(100 + k), 32'(200 + k));
      tick();
    end
    checks++;
    if (inReady !== 1'b0) begin
      failures++; $display("FAIL full_in_ready got=%b want=0", inReady);
    end
    drive_op(logicXor, 5'd0, 6'd30, 2'b11, 6'd0, 6'd0, 32'd999, 32'd999);
    tick();
    tick();
    inValid = 1'b0;
    checks++;
    if (inReady !== 1'b0) begin
      failures++; $display("FAIL full_still_full got=%b want=0", inReady);
    end
    allow = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({issueValid, funcSelect} !== {1'b1, 6'(4 + k)}) begin
        failures++;
        $display("FAIL full_order k=%0d got v=%b func=%0d want v=1 func=%0d",
                 k, issueValid, funcSelect, 4 + k);
      end
    end
    tick();
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL full_fifth_dropped got=%b want=0", issueValid);
    end
  endtask

  task automatic test_ooo();
    allow = 1'b0;
    drive_op(arithShra, 5'd2, 6'd40, 2'b01, 6'd0, 6'd7, 32'h30, 32'h0);
    tick();
    drive_op(logicShl, 5'd4, 6'd41, 2'b11, 6'd0, 6'd0, 32'h31, 32'h32);
    tick();
    inValid = 1'b0;
    push_exp(logicShl, 5'd4, 6'd41, 32'h31, 32'h32);
    push_exp(arithShra, 5'd2, 6'd40, 32'h30, 32'h77);
    allow = 1'b1;
    tick();
    checks++;
    if ({issueValid, funcSelect} !== {1'b1, logicShl}) begin
      failures++;
      $display("FAIL ooo_younger_first got v=%b func=%0d want v=1 func=6", issueValid, funcSelect);
    end
    tick();
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL ooo_older_blocked got=%b want=0", issueValid);
    end
    resValid = 1'b1;
    resTag   = 6'd7;
    resData  = 32'h77;
    tick();
    resValid = 1'b0;
`ifndef ALU_IQ_BYPASS_EN
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL ooo_capture_edge got=%b want=0", issueValid);
    end
    tick();
`endif
    checks++;
    if ({issueValid, funcSelect, dataIn1} !== {1'b1, arithShra, 32'h77}) begin
      failures++;
      $display("FAIL ooo_older_after_wakeup got v=%b func=%0d d1=%h want v=1 func=3 d1=77",
               issueValid, funcSelect, dataIn1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    allow = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_op(arithAdd, 5'(k), 6'(50 + k), 2'b11, 6'd0, 6'd0, 32'(k), 32'(k + 1));
      push_exp(arithAdd, 5'(k), 6'(50 + k), 32'(k), 32'(k + 1));
      tick();
      checks++;
      if (inReady !== 1'b1) begin
        failures++; $display("FAIL b2b_in_ready k=%0d got=%b want=1", k, inReady);
      end
      if (k > 0) begin
        checks++;
        if ({issueValid, dataIn0} !== {1'b1, 32'(k - 1)}) begin
          failures++;
          $display("FAIL b2b_issue k=%0d got v=%b d0=%0d want v=1 d0=%0d",
                   k, issueValid, dataIn0, k - 1);
        end
      end
    end
    inValid = 1'b0;
    tick();
    checks++;
    if ({issueValid, dataIn0} !== {1'b1, 32'd4}) begin
      failures++;
      $display("FAIL b2b_last got v=%b d0=%0d want v=1 d0=4", issueValid, dataIn0);
    end
    tick();
  endtask

  task automatic test_enable();
    allow = 1'b1;
    en    = 1'b1;
    drive_op(logicXor, 5'd1, 6'd60, 2'b11, 6'd0, 6'd0, 32'hAA, 32'hBB);
    push_exp(logicXor, 5'd1, 6'd60, 32'hAA, 32'hBB);
    tick();
    en = 1'b0;
    drive_op(logicAnd, 5'd0, 6'd61, 2'b11, 6'd0, 6'd0, 32'hCC, 32'hDD);
    tick();
    tick();
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL en_hold got=%b want=0", issueValid);
    end
    inValid = 1'b0;
    en      = 1'b1;
    tick();
    checks++;
    if ({issueValid, funcSelect} !== {1'b1, logicXor}) begin
      failures++;
      $display("FAIL en_resume got v=%b func=%0d want v=1 func=8", issueValid, funcSelect);
    end
    tick();
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL en_ignored_insert got=%b want=0", issueValid);
    end
  endtask

  task automatic test_flush();
    allow = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_op(logicAnd, 5'd0, 6'(70 + k), 2'b11, 6'd0, 6'd0, 32'(768 + k), 32'd0);
      tick();
    end
    inValid = 1'b0;
    push_exp(logicAnd, 5'd0, 6'd70, 32'd768, 32'd0);
    allow = 1'b1;
    tick();
    checks++;
    if ({issueValid, dataIn0} !== {1'b1, 32'd768}) begin
      failures++;
      $display("FAIL flush_pre_issue got v=%b d0=%0d want v=1 d0=768", issueValid, dataIn0);
    end
    allow = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({issueValid, inReady} !== 2'b01) begin
      failures++;
      $display("FAIL flush_state got v=%b in_ready=%b want v=0 in_ready=1", issueValid, inReady);
    end
    allow = 1'b1;
    tick();
    tick();
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL flush_empty got=%b want=0", issueValid);
    end
  endtask

  task automatic test_reset_mid();
    allow = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_op(logicShrl, 5'(k + 1), 6'(80 + k), 2'b11, 6'd0, 6'd0, 32'(900 + k), 32'd1);
      tick();
    end
    inValid = 1'b0;
    push_exp(logicShrl, 5'd1, 6'd80, 32'd900, 32'd1);
    allow = 1'b1;
    tick();
    checks++;
    if (issueValid !== 1'b1) begin
      failures++; $display("FAIL reset_mid_pre got=%b want=1", issueValid);
    end
    allow = 1'b0;
    en    = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en    = 1'b1;
    checks++;
    if ({issueValid, funcSelect, dataIn0, dataIn1, c0, issueTag} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got v=%b func=%0d d0=%h d1=%h c0=%0d tag=%0d want all 0",
               issueValid, funcSelect, dataIn0, dataIn1, c0, issueTag);
    end
    checks++;
    if (inReady !== 1'b1) begin
      failures++; $display("FAIL reset_mid_in_ready got=%b want=1", inReady);
    end
    allow = 1'b1;
    tick();
    checks++;
    if (issueValid !== 1'b0) begin
      failures++; $display("FAIL reset_mid_cleared got=%b want=0", issueValid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_same_edge_wakeup();
    test_full();
    test_ooo();
    test_back_to_back();
    test_enable();
    test_flush();
    test_reset_mid();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_leftover got=%0d pending want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
